conv_enc_frame_ctrl: RTL and testbench
======================================

Name: conv_enc_frame_ctrl

Overview:
Frame sequencer for the Convolutional_Encoder in the 802.11a PHY transmit chain. It runs the encoder through one PPDU in two phases:
- SIGNAL field: 24 bits at rate 1/2.
- DATA field: data_len payload bits at the selected rate, followed by 6 zero tail bits.

It pulls bits from the upstream scrambler, flushes the encoder state between fields, counts encoder output bits against the expected count, and reports done or error to the PHY top controller.

Parameters:
- LEN_W, 12, width of data_len (payload bits per frame)
- CNT_W, 14, width of output-bit counters
- SIG_BITS, 24, SIGNAL field input bits
- TAIL_BITS, 6, zero tail bits appended to DATA
- TIMEOUT, 64, max cycles in a WAIT state without reaching the expected output count

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start; sampled only in IDLE
- rate_mode  in  2  DATA rate: 0 = 1/2, 1 = 3/4, 2 = 2/3, 3 = reserved
- data_len  in  LEN_W  payload bits; sampled with start
- src_valid  in  1  upstream bit valid
- src_bit  in  1  upstream bit
- src_ready  out  1  controller accepts src_bit this cycle
- enc_reset  out  1  encoder synchronous reset / flush
- enc_mode  out  2  encoder mode
- enc_data_in  out  1  encoder data_in
- enc_in_valid  out  1  encoder inputValid
- enc_out_valid  in  1  encoder outputValid
- phase  out  1  0 = SIGNAL, 1 = DATA; tags encoder output for the interleaver
- out_cnt  out  CNT_W  encoder output bits counted in the current phase
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on successful frame completion
- err  out  1  one-cycle pulse on error
- err_code  out  2  1 = reserved mode, 2 = bad length, 3 = timeout; holds until next start

Behaviour:
- Interface: one clock domain, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - FSM returns to IDLE.
  - All outputs are 0, except enc_reset = 1.
  - Counters are cleared; err_code = 0.
- States: IDLE, FLUSH_S, SIG, WAIT_S, FLUSH_D, DATA, TAIL, WAIT_D, DONE, ERR.
- IDLE:
  - enc_reset = 1.
  - start with rate_mode = 3 goes to ERR, err_code = 1.
  - Any other start latches rate_mode and data_len, then goes to FLUSH_S.
- FLUSH_S / FLUSH_D:
  - Exactly one cycle with enc_reset = 1.
  - Clears out_cnt, exp_cnt, grp_cnt and in_cnt.
  - enc_mode is 0 in FLUSH_S and the latched mode in FLUSH_D; it is held stable for the whole phase.
- Input handshake (SIG, DATA):
  - src_ready = 1.
  - A transfer happens when src_valid && src_ready. On a transfer: enc_data_in = src_bit and enc_in_valid = 1 in the same cycle (combinational pass-through), and in_cnt increments.
  - When src_valid is low, enc_in_valid = 0; the encoder simply stalls.
- SIG: after SIG_BITS transfers, go to WAIT_S.
- DATA: after data_len transfers, go to TAIL. data_len = 0 goes straight to TAIL.
- TAIL:
  - src_ready = 0.
  - Drives enc_in_valid = 1 with enc_data_in = 0 for TAIL_BITS consecutive cycles.
  - Then goes to WAIT_D if grp_cnt == 0, else to ERR with err_code = 2.
- Expected-count accumulation, per encoder input bit (payload or tail):
  - mode 0: exp_cnt += 2.
  - mode 1: grp_cnt cycles 0..2; add 4 when it wraps.
  - mode 2: grp_cnt cycles 0..1; add 3 when it wraps.
  - No divider is used.
- Output counting: out_cnt increments on every enc_out_valid cycle while busy, in every state, including during input transfers.
- WAIT_S / WAIT_D:
  - Exit when out_cnt == exp_cnt: WAIT_S goes to FLUSH_D, WAIT_D goes to DONE.
  - If out_cnt == exp_cnt already holds on entry, exit on the next cycle.
  - A watchdog counts cycles in the WAIT state; reaching TIMEOUT goes to ERR with err_code = 3.
- DONE: done = 1 for one cycle, then IDLE.
- ERR: err = 1 for one cycle, then IDLE; enc_reset is asserted on entry to IDLE.
- phase is 0 from FLUSH_S through WAIT_S, and 1 from FLUSH_D through DONE.
- start while busy is ignored.
- reset mid-frame aborts immediately:
  - No done/err pulse is produced.
  - Counters are cleared and the encoder is flushed via enc_reset.

Decomposition:
- Package conv_enc_pkg holds:
  - Rate mode constants (RATE_1_2 = 0, RATE_3_4 = 1, RATE_2_3 = 2).
  - FSM state encoding.
  - err_code constants.
  - SIG_BITS and TAIL_BITS defaults.
- One sub-module, conv_enc_rate_acc: holds grp_cnt and exp_cnt and implements the per-input-bit expected-output accumulation for the latched mode.

Test Plan:
- rate_mode = 2, data_len = 102, upstream always valid, encoder model attached:
  - 24 SIGNAL bits produce exactly 48 outputs with phase = 0.
  - DATA produces 162 outputs with phase = 1.
  - done pulses once; err never asserts.
- rate_mode = 0, data_len = 100, src_valid toggling every other cycle:
  - exp_cnt = 212; done asserts.
  - enc_in_valid is never high while src_valid is low outside TAIL.
- rate_mode = 1, data_len = 102 gives 144 DATA outputs and done.
- rate_mode = 1, data_len = 100 (106 total inputs, 106 mod 3 = 1) gives err with err_code = 2 right after the 6th tail bit.
- Edge and fault cases:
  - rate_mode = 3 at start: err on the 2nd cycle with err_code = 1; no src_ready ever asserted.
  - Encoder model drops its last output: err_code = 3 after exactly 64 WAIT_D cycles.
- reset asserted mid-DATA (bit 50):
  - Next cycle is IDLE with all outputs at reset values and enc_reset = 1.
  - No done/err pulse.
  - A following frame with rate_mode = 2, data_len = 102 completes with 162 outputs.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// Shared definitions for the 802.11a convolutional-encoder frame sequencer.
// Holds the DATA rate encodings, the sequencer state encoding, the error
// codes reported to the PHY top controller and the default field sizes.
package conv_enc_pkg;

   localparam int unsigned SIG_BITS_DEF  = 24;
   localparam int unsigned TAIL_BITS_DEF = 6;

   typedef enum logic [1:0] {
      RATE_1_2  = 2'd0,
      RATE_3_4  = 2'd1,
      RATE_2_3  = 2'd2,
      RATE_RSVD = 2'd3
   } rate_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FLUSH_S,
      ST_SIG,
      ST_WAIT_S,
      ST_FLUSH_D,
      ST_DATA,
      ST_TAIL,
      ST_WAIT_D,
      ST_DONE,
      ST_ERR
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_MODE    = 2'd1,
      ERR_LEN     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_e;

   // DATA phase spans FLUSH_D through DONE; everything else tags as SIGNAL.
   function automatic logic in_data_phase(input state_e st);
      return (st == ST_FLUSH_D) || (st == ST_DATA) || (st == ST_TAIL) ||
             (st == ST_WAIT_D)  || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/conv_enc_frame_ctrl_if.sv
// Bit-stream handshake between the frame sequencer, the upstream scrambler
// and the Convolutional_Encoder.
//   master : sequencer side (drives src_ready and all encoder controls)
//   slave  : environment side (scrambler source + encoder)
interface conv_enc_frame_ctrl_if;
   logic       src_valid;
   logic       src_bit;
   logic       src_ready;
   logic       enc_reset;
   logic [1:0] enc_mode;
   logic       enc_data_in;
   logic       enc_in_valid;
   logic       enc_out_valid;

   modport master (
      input  src_valid, src_bit, enc_out_valid,
      output src_ready, enc_reset, enc_mode, enc_data_in, enc_in_valid
   );

   modport slave (
      output src_valid, src_bit, enc_out_valid,
      input  src_ready, enc_reset, enc_mode, enc_data_in, enc_in_valid
   );
endinterface

// File: rtl/conv_enc_rate_acc.sv
// Expected encoder-output accumulator. For every encoder input bit it adds
// the number of coded bits the selected rate produces, without a divider:
// rate 1/2 adds 2 per bit, rate 3/4 adds 4 per group of 3, rate 2/3 adds 3
// per group of 2.
//   clock, reset : system clock, synchronous active-high reset
//   clear_i      : zero exp_cnt and grp_cnt (field flush)
//   bit_i        : one encoder input bit accepted this cycle
//   mode_i       : rate applied to bit_i
//   exp_cnt_o    : accumulated expected output count
//   grp_nxt_o    : group position including this cycle's bit
module conv_enc_rate_acc
   import conv_enc_pkg::*;
#(
   parameter int unsigned CNT_W = 14
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             bit_i,
   input  logic [1:0]       mode_i,
   output logic [CNT_W-1:0] exp_cnt_o,
   output logic [1:0]       grp_nxt_o
);

   logic [CNT_W-1:0] exp_q, exp_d;
   logic [1:0]       grp_q, grp_d;

   always_comb begin
      exp_d = exp_q;
      grp_d = grp_q;
      if (clear_i) begin
         exp_d = '0;
         grp_d = '0;
      end else if (bit_i) begin
         case (mode_i)
            RATE_1_2: begin
               exp_d = exp_q + CNT_W'(2);
               grp_d = '0;
            end
            RATE_3_4: begin
               if (grp_q == 2'd2) begin
                  grp_d = '0;
                  exp_d = exp_q + CNT_W'(4);
               end else begin
                  grp_d = grp_q + 2'd1;
               end
            end
            RATE_2_3: begin
               if (grp_q == 2'd1) begin
                  grp_d = '0;
                  exp_d = exp_q + CNT_W'(3);
               end else begin
                  grp_d = grp_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         exp_q <= '0;
         grp_q <= '0;
      end else begin
         exp_q <= exp_d;
         grp_q <= grp_d;
      end
   end

   assign exp_cnt_o = exp_q;
   assign grp_nxt_o = grp_d;

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for the 802.11a Convolutional_Encoder. Runs one PPDU as a
// 24-bit rate-1/2 SIGNAL field followed by data_len payload bits plus 6 zero
// tail bits at the selected rate, flushing the encoder between fields and
// checking the encoder output count against the expected count.
//   clock, reset : system clock, synchronous active-high reset
//   start        : frame start pulse, sampled only in IDLE
//   rate_mode    : DATA rate (0 = 1/2, 1 = 3/4, 2 = 2/3, 3 = reserved)
//   data_len     : payload bits, sampled with start
//   bus          : scrambler source handshake and encoder controls
//   phase        : 0 = SIGNAL, 1 = DATA
//   out_cnt      : encoder outputs counted in the current field
//   busy         : high outside IDLE
//   done, err    : one-cycle completion / error pulses
//   err_code     : 1 reserved mode, 2 bad length, 3 timeout; held to next start
module conv_enc_frame_ctrl
   import conv_enc_pkg::*;
#(
   parameter int unsigned LEN_W     = 12,
   parameter int unsigned CNT_W     = 14,
   parameter int unsigned SIG_BITS  = SIG_BITS_DEF,
   parameter int unsigned TAIL_BITS = TAIL_BITS_DEF,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [1:0]             rate_mode,
   input  logic [LEN_W-1:0]       data_len,
   conv_enc_frame_ctrl_if.master  bus,
   output logic                   phase,
   output logic [CNT_W-1:0]       out_cnt,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              xfer;
   logic              tail_bit;
   logic              flush;
   logic [1:0]        enc_mode;
   logic [CNT_W-1:0]  exp_cnt;
   logic [1:0]        grp_nxt;

   // Source bits pass straight through to the encoder in the accepting cycle.
   assign xfer     = ((state_q == ST_SIG) || (state_q == ST_DATA)) && bus.src_valid;
   assign tail_bit = (state_q == ST_TAIL);
   assign flush    = (state_q == ST_FLUSH_S) || (state_q == ST_FLUSH_D);
   assign phase    = in_data_phase(state_q);
   assign enc_mode = phase ? mode_q : RATE_1_2;

   assign bus.src_ready    = (state_q == ST_SIG) || (state_q == ST_DATA);
   assign bus.enc_in_valid = xfer || tail_bit;
   assign bus.enc_data_in  = xfer && bus.src_bit;
   assign bus.enc_reset    = (state_q == ST_IDLE) || flush;
   assign bus.enc_mode     = enc_mode;

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign err      = (state_q == ST_ERR);
   assign out_cnt  = out_cnt_q;
   assign err_code = err_code_q;

   conv_enc_rate_acc #(
      .CNT_W (CNT_W)
   ) u_acc (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (flush),
      .bit_i     (bus.enc_in_valid),
      .mode_i    (enc_mode),
      .exp_cnt_o (exp_cnt),
      .grp_nxt_o (grp_nxt)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      len_d      = len_q;
      in_cnt_d   = in_cnt_q;
      wd_d       = wd_q;
      err_code_d = err_code_q;
      out_cnt_d  = out_cnt_q;
      if (busy && bus.enc_out_valid) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (rate_mode == RATE_RSVD) begin
                  err_code_d = ERR_MODE;
                  state_d    = ST_ERR;
               end else begin
                  mode_d     = rate_mode;
                  len_d      = data_len;
                  err_code_d = ERR_NONE;
                  state_d    = ST_FLUSH_S;
               end
            end
         end
         ST_FLUSH_S: begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = ST_SIG;
         end
         ST_SIG: begin
            if (xfer) begin
               in_cnt_d = in_cnt_q + LEN_W'(1);
               if (in_cnt_q == LEN_W'(SIG_BITS - 1)) begin
                  wd_d    = '0;
                  state_d = ST_WAIT_S;
               end
            end
         end
         ST_WAIT_S: begin
            if (out_cnt_q == exp_cnt) begin
               state_d = ST_FLUSH_D;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_ERR;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         ST_FLUSH_D: begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = (len_q == '0) ? ST_TAIL : ST_DATA;
         end
         ST_DATA: begin
            if (xfer) begin
               in_cnt_d = in_cnt_q + LEN_W'(1);
               if (in_cnt_q == len_q - LEN_W'(1)) begin
                  in_cnt_d = '0;
                  state_d  = ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            in_cnt_d = in_cnt_q + LEN_W'(1);
            if (in_cnt_q == LEN_W'(TAIL_BITS - 1)) begin
               in_cnt_d = '0;
               wd_d     = '0;
               // Group position must include the final tail bit, hence grp_nxt.
               if (grp_nxt == 2'd0) begin
                  state_d = ST_WAIT_D;
               end else begin
                  err_code_d = ERR_LEN;
                  state_d    = ST_ERR;
               end
            end
         end
         ST_WAIT_D: begin
            if (out_cnt_q == exp_cnt) begin
               state_d = ST_DONE;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_ERR;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         len_q      <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         wd_q       <= '0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         len_q      <= len_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         wd_q       <= wd_d;
         err_code_q <= err_code_d;
      end
   end

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl with a punctured-encoder model:
// rate 1/2 emits 2 bits per input, rate 3/4 emits 2,1,1 per group of three,
// rate 2/3 emits 2,1 per pair; outputs leave one per cycle.
module tb_conv_enc_frame_ctrl;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  rate_mode;
   logic [11:0] data_len;
   logic        phase;
   logic [13:0] out_cnt;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   conv_enc_frame_ctrl_if bus ();

   conv_enc_frame_ctrl #(
      .LEN_W     (12),
      .CNT_W     (14),
      .SIG_BITS  (24),
      .TAIL_BITS (6),
      .TIMEOUT   (64)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .rate_mode (rate_mode),
      .data_len  (data_len),
      .bus       (bus),
      .phase     (phase),
      .out_cnt   (out_cnt),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- encoder model ----------------
   bit drop_one;
   int m_pend_q, m_pend_d, m_grp_q, m_grp_d, m_add;
   bit m_drop_q, m_drop_d, m_ov_d;

   always_comb begin
      m_add    = 0;
      m_grp_d  = m_grp_q;
      m_drop_d = m_drop_q;
      if (bus.enc_in_valid) begin
         if (bus.enc_mode == 2'd0) begin
            m_add = 2;
         end else begin
            m_add = (m_grp_q == 0) ? 2 : 1;
            if (bus.enc_mode == 2'd1) m_grp_d = (m_grp_q == 2) ? 0 : m_grp_q + 1;
            else                      m_grp_d = (m_grp_q == 1) ? 0 : m_grp_q + 1;
         end
         if (drop_one && phase && !m_drop_q) begin
            m_add    = m_add - 1;
            m_drop_d = 1'b1;
         end
      end
      if (!drop_one) m_drop_d = 1'b0;
      m_pend_d = m_pend_q + m_add;
      m_ov_d   = 1'b0;
      if (m_pend_d != 0) begin
         m_ov_d   = 1'b1;
         m_pend_d = m_pend_d - 1;
      end
      if (bus.enc_reset) begin
         m_pend_d = 0;
         m_grp_d  = 0;
         m_ov_d   = 1'b0;
      end
   end

   always @(posedge clock) begin
      m_pend_q          <= m_pend_d;
      m_grp_q           <= m_grp_d;
      m_drop_q          <= m_drop_d;
      bus.enc_out_valid <= m_ov_d;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int r_out0, r_out1, r_viol, r_tail, r_last_tail;
   int r_done, r_err, r_err_cyc, r_done_cnt, r_code;
   bit r_ready_seen, r_timeout;

   task automatic sample(input int cyc);
      if (busy && bus.enc_out_valid) begin
         if (phase) r_out1++;
         else       r_out0++;
      end
      if (bus.enc_in_valid && !bus.src_valid && bus.src_ready) r_viol++;
      if (bus.src_ready) r_ready_seen = 1'b1;
      if (bus.enc_in_valid && !bus.src_ready) begin
         r_tail++;
         r_last_tail = cyc;
      end
      if (done) begin
         if (r_done == 0) r_done_cnt = int'(out_cnt);
         r_done++;
      end
      if (err) begin
         if (r_err == 0) begin
            r_err_cyc = cyc;
            r_code    = int'(err_code);
         end
         r_err++;
      end
   endtask

   task automatic run_frame(input logic [1:0] m, input logic [11:0] len, input bit toggle);
      bit fin;
      fin = 1'b0;
      r_out0 = 0; r_out1 = 0; r_viol = 0; r_tail = 0; r_last_tail = 0;
      r_done = 0; r_err = 0; r_err_cyc = 0; r_done_cnt = 0; r_code = 0;
      r_ready_seen = 1'b0; r_timeout = 1'b0;
      @(negedge clock);
      start         = 1'b1;
      rate_mode     = m;
      data_len      = len;
      bus.src_valid = !toggle;
      bus.src_bit   = 1'b0;
      @(negedge clock);
      start = 1'b0;
      for (int cyc = 1; cyc <= 1500 && !fin; cyc++) begin
         sample(cyc);
         if (done || err) fin = 1'b1;
         if (toggle) bus.src_valid = !bus.src_valid;
         bus.src_bit = 1'($urandom);
         @(negedge clock);
      end
      if (!fin) r_timeout = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample(100000);
         @(negedge clock);
      end
   endtask

   int xcnt;

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      rate_mode     = 2'd0;
      data_len      = '0;
      bus.src_valid = 1'b0;
      bus.src_bit   = 1'b0;
      drop_one      = 1'b0;
      repeat (3) @(negedge clock);

      // reset state
      check("rst_enc_reset", 32'(bus.enc_reset), 32'd1);
      check("rst_outputs", {busy, done, err, phase, bus.src_ready, bus.enc_in_valid,
                            bus.enc_data_in, bus.enc_mode, err_code, out_cnt}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // rate 2/3, 102 bits, source always valid
      run_frame(2'd2, 12'd102, 1'b0);
      check("r23_end", 32'(r_timeout), 32'd0);
      check("r23_sig_outs", r_out0, 48);
      check("r23_data_outs", r_out1, 162);
      check("r23_out_cnt", r_done_cnt, 162);
      check("r23_done", r_done, 1);
      check("r23_err", r_err, 0);

      // rate 1/2, 100 bits, source valid every other cycle
      run_frame(2'd0, 12'd100, 1'b1);
      check("r12_end", 32'(r_timeout), 32'd0);
      check("r12_exp_cnt", r_done_cnt, 212);
      check("r12_done", r_done, 1);
      check("r12_stall", r_viol, 0);
      check("r12_sig_outs", r_out0, 48);

      // rate 3/4, 102 bits
      run_frame(2'd1, 12'd102, 1'b0);
      check("r34_data_outs", r_out1, 144);
      check("r34_done", r_done, 1);

      // rate 3/4, 100 bits: 106 inputs is not a whole number of groups
      run_frame(2'd1, 12'd100, 1'b0);
      check("len_err", r_err, 1);
      check("len_code", r_code, 2);
      check("len_tail_bits", r_tail, 6);
      check("len_err_latency", r_err_cyc - r_last_tail, 1);
      check("len_no_done", r_done, 0);
      check("len_code_held", 32'(err_code), 32'd2);

      // zero-length payload: only the tail is encoded
      run_frame(2'd0, 12'd0, 1'b0);
      check("len0_outs", r_done_cnt, 12);
      check("len0_done", r_done, 1);
      check("len0_code_clr", 32'(err_code), 32'd0);

      // reserved rate
      run_frame(2'd3, 12'd50, 1'b0);
      check("rsvd_err_cycle", r_err_cyc, 1);
      check("rsvd_code", r_code, 1);
      check("rsvd_no_ready", 32'(r_ready_seen), 32'd0);

      // encoder loses one DATA output
      drop_one = 1'b1;
      run_frame(2'd0, 12'd10, 1'b0);
      drop_one = 1'b0;
      check("tmo_code", r_code, 3);
      check("tmo_wait_cycles", r_err_cyc - r_last_tail, 65);
      check("tmo_no_done", r_done, 0);

      // reset in the middle of DATA
      @(negedge clock);
      start         = 1'b1;
      rate_mode     = 2'd0;
      data_len      = 12'd100;
      bus.src_valid = 1'b1;
      @(negedge clock);
      start = 1'b0;
      xcnt  = 0;
      for (int cyc = 0; cyc < 400 && xcnt < 50; cyc++) begin
         if (phase && bus.src_ready && bus.src_valid) xcnt++;
         if (xcnt < 50) @(negedge clock);
      end
      check("mid_reached_bit50", xcnt, 50);
      reset = 1'b1;
      @(negedge clock);
      check("mid_enc_reset", 32'(bus.enc_reset), 32'd1);
      check("mid_outputs", {busy, done, err, phase, bus.src_ready, bus.enc_in_valid,
                            bus.enc_data_in, bus.enc_mode, err_code, out_cnt}, 32'd0);
      reset  = 1'b0;
      r_done = 0;
      r_err  = 0;
      for (int k = 0; k < 5; k++) begin
         if (done) r_done++;
         if (err)  r_err++;
         @(negedge clock);
      end
      check("mid_no_pulse", r_done + r_err, 0);

      run_frame(2'd2, 12'd102, 1'b0);
      check("post_rst_outs", r_done_cnt, 162);
      check("post_rst_done", r_done, 1);
      check("post_rst_err", r_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
